// File: rtl/cache_pkg.sv
// Shared types and constants for the two-way instruction cache.
// Default geometry: 16 sets of 4-word lines.
package cache_pkg;
  localparam int SETS = 16;
  localparam int WORDS = 4;
  localparam int INDEX_W = $clog2(SETS);
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_AR,
    REFILL_R,
    RESPOND
  } fsm_state_t;
endpackage

// File: rtl/cache_tag_data_array.sv
// Two-way tag/valid/data storage with per-set LRU bit.
// Registered read of a whole set; whole-line write port.
module cache_tag_data_array
  import cache_pkg::*;
#(
  parameter int NSETS = SETS,
  parameter int NWORDS = WORDS,
  parameter int IW = INDEX_W,
  parameter int TW = TAG_W,
  parameter int DW = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic [IW-1:0]                   rd_idx,
  output logic [1:0]                      rd_valid,
  output logic [1:0][TW-1:0]              rd_tag,
  output logic [1:0][NWORDS-1:0][DW-1:0]  rd_data,
  output logic                            rd_lru,
  input  logic                            lru_we,
  input  logic [IW-1:0]                   lru_idx,
  input  logic                            lru_val,
  input  logic                            wr_en,
  input  logic                            wr_way,
  input  logic [IW-1:0]                   wr_idx,
  input  logic [TW-1:0]                   wr_tag,
  input  logic                            wr_valid,
  input  logic [NWORDS-1:0][DW-1:0]       wr_line
);
  logic [NSETS-1:0] valid_q [2];
  logic [NSETS-1:0] lru_q;
  logic [TW-1:0] tag_q [2][NSETS];
  logic [NWORDS-1:0][DW-1:0] data_q [2][NSETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q <= '0;
    end else begin
      if (wr_en) valid_q[wr_way][wr_idx] <= wr_valid;
      if (lru_we) lru_q[lru_idx] <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][wr_idx] <= wr_tag;
      data_q[wr_way][wr_idx] <= wr_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_valid <= {valid_q[1][rd_idx], valid_q[0][rd_idx]};
      rd_tag <= {tag_q[1][rd_idx], tag_q[0][rd_idx]};
      rd_data[0] <= data_q[0][rd_idx];
      rd_data[1] <= data_q[1][rd_idx];
      rd_lru <= lru_q[rd_idx];
    end
  end
endmodule

// File: rtl/complex_cache_test_top.sv
// Two-way read-only I-cache: req/gnt/rvalid fetch port,
// AXI4 INCR line refill on miss.
module complex_cache_test_top
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS = SETS,
  parameter int LINE_WORDS = WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = ADDR_WIDTH - IW - OW - 2;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

  fsm_state_t state;
  logic [ADDR_WIDTH-1:0] addr_q, araddr_q;
  logic [OW-1:0] cnt_q;
  logic err_q, victim_q;
  line_t buf_q, line_w;

  logic [1:0] rd_valid, hit_w;
  logic [1:0][TW-1:0] rd_tag;
  logic [1:0][LINE_WORDS-1:0][DATA_WIDTH-1:0] rd_data;
  logic rd_lru, hit, hit_way, victim;
  logic fill_we, fill_ok, lookup;
  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;

  assign off = addr_q[2 +: OW];
  assign idx = addr_q[2+OW +: IW];
  assign tag = addr_q[2+OW+IW +: TW];

  assign hit_w[0] = rd_valid[0] && rd_tag[0] == tag;
  assign hit_w[1] = rd_valid[1] && rd_tag[1] == tag;
  assign hit = |hit_w;
  assign hit_way = !hit_w[0];
  assign lookup = state == LOOKUP;

  // Fill invalid ways first, then fall back to LRU.
  assign victim = !rd_valid[0] ? 1'b0 :
                  !rd_valid[1] ? 1'b1 : rd_lru;

  assign fill_we = state == REFILL_R && m_axi_rvalid
                   && m_axi_rlast;
  assign fill_ok = !err_q && m_axi_rresp == AXI_RESP_OKAY;

  always_comb begin
    line_w = buf_q;
    line_w[cnt_q] = m_axi_rdata;
  end

  assign instr_gnt_o = state == IDLE && instr_req_i;
  assign instr_rvalid_o = (lookup && hit) || state == RESPOND;

  always_comb begin
    instr_rdata_o = '0;
    if (lookup && hit) instr_rdata_o = rd_data[hit_way][off];
    else if (state == RESPOND) instr_rdata_o = buf_q[off];
  end

  assign m_axi_arvalid = state == REFILL_AR;
  assign m_axi_rready = state == REFILL_R;
  assign m_axi_araddr = araddr_q;
  assign m_axi_arlen = 8'(LINE_WORDS - 1);
  assign m_axi_arsize = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;

  cache_tag_data_array #(
    .NSETS (NUM_SETS),
    .NWORDS(LINE_WORDS),
    .IW    (IW),
    .TW    (TW),
    .DW    (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst_n),
    .rd_en   (instr_gnt_o),
    .rd_idx  (instr_addr_i[2+OW +: IW]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .rd_lru  (rd_lru),
    .lru_we  ((lookup && hit) || (fill_we && fill_ok)),
    .lru_idx (idx),
    .lru_val (lookup ? !hit_way : !victim_q),
    .wr_en   (fill_we),
    .wr_way  (victim_q),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_valid(fill_ok),
    .wr_line (line_w)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      araddr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      victim_q <= 1'b0;
      buf_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (instr_req_i) begin
          addr_q <= instr_addr_i;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) state <= IDLE;
        else begin
          victim_q <= victim;
          araddr_q <= addr_q & ~LINE_MASK;
          state <= REFILL_AR;
        end
        REFILL_AR: if (m_axi_arready) begin
          cnt_q <= '0;
          err_q <= 1'b0;
          state <= REFILL_R;
        end
        REFILL_R: if (m_axi_rvalid) begin
          buf_q[cnt_q] <= m_axi_rdata;
          cnt_q <= cnt_q + 1'b1;
          if (m_axi_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
          if (m_axi_rlast) state <= RESPOND;
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_cache_test_top.sv
// Directed bench for the two-way I-cache with an AXI
// read-slave model that supports stalls, beat gaps and errors.
module tb_complex_cache_test_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [31:0] addr = '0;
  logic gnt, rvalid;
  logic [31:0] rdata;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, rready;
  logic arready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0] s_rresp = '0;
  logic s_rlast = 1'b0;
  logic s_rvalid = 1'b0;

  int errors = 0;
  int checks = 0;

  int ar_delay = 0;
  int beat_gap = 0;
  int err_beat = -1;
  int ar_count = 0;
  logic [31:0] cap_addr = '0;
  logic [7:0] cap_len = '0;
  logic [2:0] cap_size = '0;
  logic [1:0] cap_burst = '0;

  int stall_run = 0;
  int stall_max = 0;
  bit stall_bad = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_ad = '0;

  always #5 clk = ~clk;

  complex_cache_test_top dut (
    .clk           (clk),
    .rst_n         (rst),
    .instr_req_i   (req),
    .instr_addr_i  (addr),
    .instr_gnt_o   (gnt),
    .instr_rvalid_o(rvalid),
    .instr_rdata_o (rdata),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (s_rdata),
    .m_axi_rresp   (s_rresp),
    .m_axi_rlast   (s_rlast),
    .m_axi_rvalid  (s_rvalid),
    .m_axi_rready  (rready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h80:  return 32'h2400006f;
      32'h84:  return 32'h25c0006f;
      32'h200: return 32'hfe010113;
      default: return a >> 2;
    endcase
  endfunction

  // AR must hold steady while stalled.
  always @(negedge clk) begin
    if (prev_stall && !(arvalid && araddr == prev_ad))
      stall_bad = 1'b1;
    prev_stall = arvalid && !arready;
    prev_ad = araddr;
    if (prev_stall) begin
      stall_run++;
      if (stall_run > stall_max) stall_max = stall_run;
    end else stall_run = 0;
  end

  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk); #2;
      if (arvalid && !rst) begin
        repeat (ar_delay) begin @(posedge clk); #2; end
        arready = 1'b1;
        a = araddr;
        cap_addr = araddr;
        cap_len = arlen;
        cap_size = arsize;
        cap_burst = arburst;
        @(posedge clk); #2;
        arready = 1'b0;
        ar_count++;
        for (int i = 0; i <= int'(cap_len); i++) begin
          s_rvalid = 1'b1;
          s_rdata = mem_word(a + 32'(4 * i));
          s_rresp = (i == err_beat) ? 2'b10 : 2'b00;
          s_rlast = (i == int'(cap_len));
          @(posedge clk); #2;
          s_rvalid = 1'b0;
          s_rlast = 1'b0;
          s_rresp = 2'b00;
          repeat (beat_gap) begin @(posedge clk); #2; end
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a,
                       output logic [31:0] d,
                       output int lat, output int ars);
    int n;
    int ar0;
    ar0 = ar_count;
    d = '0;
    lat = -1;
    @(negedge clk);
    req = 1'b1;
    addr = a;
    #1;
    n = 0;
    while (!gnt && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (gnt) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      lat = 1;
      while (!rvalid && lat < 300) begin
        @(negedge clk); #1; lat++;
      end
      if (rvalid) d = rdata;
      else lat = -1;
    end else req = 1'b0;
    ars = ar_count - ar0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({gnt, rvalid, arvalid, rready} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctl got %b want 0000",
               {gnt, rvalid, arvalid, rready});
    end
    checks++;
    if (araddr !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h/%h want 0/0", araddr, rdata);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({gnt, rvalid, arvalid, rready} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ctl got %b want 0000",
               {gnt, rvalid, arvalid, rready});
    end
    checks++;
    if (ar_count !== 0) begin
      errors++;
      $display("FAIL idle_ar got %0d want 0", ar_count);
    end
  endtask

  task automatic test_miss;
    logic [31:0] d;
    int lat, ars;
    fetch(32'h80, d, lat, ars);
    checks++;
    if (d !== 32'h2400006f) begin
      errors++;
      $display("FAIL miss_data got %h want 2400006f", d);
    end
    checks++;
    if (ars !== 1) begin
      errors++;
      $display("FAIL miss_ar got %0d want 1", ars);
    end
    checks++;
    if (cap_addr !== 32'h80) begin
      errors++;
      $display("FAIL miss_araddr got %h want 80", cap_addr);
    end
    checks++;
    if ({cap_len, cap_size, cap_burst} !== {8'd3, 3'd2, 2'd1})
    begin
      errors++;
      $display("FAIL miss_arattr got %0d/%0d/%0d want 3/2/1",
               cap_len, cap_size, cap_burst);
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL miss_lat got %0d want 7", lat);
    end
  endtask

  task automatic test_hit;
    logic [31:0] d;
    int lat, ars;
    fetch(32'h84, d, lat, ars);
    checks++;
    if (d !== 32'h25c0006f) begin
      errors++;
      $display("FAIL hit_data got %h want 25c0006f", d);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL hit_lat got %0d want 1", lat);
    end
    checks++;
    if (ars !== 0) begin
      errors++;
      $display("FAIL hit_ar got %0d want 0", ars);
    end
  endtask

  task automatic test_conflict;
    logic [31:0] av [5];
    logic [31:0] dv [5];
    int lv [5];
    int arv [5];
    logic [31:0] d;
    int lat, ars;
    av = '{32'h200, 32'h300, 32'h400, 32'h300, 32'h200};
    dv = '{32'hfe010113, 32'hc0, 32'h100, 32'hc0, 32'hfe010113};
    arv = '{1, 1, 1, 0, 1};
    lv = '{7, 7, 7, 1, 7};
    for (int i = 0; i < 5; i++) begin
      fetch(av[i], d, lat, ars);
      checks++;
      if (d !== dv[i]) begin
        errors++;
        $display("FAIL conf_data[%0d] got %h want %h", i, d, dv[i]);
      end
      checks++;
      if (ars !== arv[i]) begin
        errors++;
        $display("FAIL conf_ar[%0d] got %0d want %0d",
                 i, ars, arv[i]);
      end
      checks++;
      if (lat !== lv[i]) begin
        errors++;
        $display("FAIL conf_lat[%0d] got %0d want %0d",
                 i, lat, lv[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    int lat, ars;
    ar_delay = 5;
    beat_gap = 2;
    stall_bad = 1'b0;
    stall_max = 0;
    fetch(32'h61c, d, lat, ars);
    checks++;
    if (d !== 32'h187) begin
      errors++;
      $display("FAIL bp_data got %h want 00000187", d);
    end
    checks++;
    if (stall_bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_stable got %0d want 0", stall_bad);
    end
    checks++;
    if (stall_max !== 5) begin
      errors++;
      $display("FAIL bp_stall got %0d want 5", stall_max);
    end
    checks++;
    if (cap_addr !== 32'h610) begin
      errors++;
      $display("FAIL bp_araddr got %h want 610", cap_addr);
    end
    repeat (10) @(negedge clk);
    ar_delay = 0;
    beat_gap = 0;
  endtask

  task automatic test_error;
    logic [31:0] d;
    int lat, ars;
    err_beat = 2;
    fetch(32'h500, d, lat, ars);
    err_beat = -1;
    checks++;
    if (d !== 32'h140) begin
      errors++;
      $display("FAIL err_data got %h want 00000140", d);
    end
    checks++;
    if (ars !== 1) begin
      errors++;
      $display("FAIL err_ar got %0d want 1", ars);
    end
    fetch(32'h500, d, lat, ars);
    checks++;
    if (ars !== 1) begin
      errors++;
      $display("FAIL err_refetch_ar got %0d want 1", ars);
    end
    checks++;
    if (d !== 32'h140) begin
      errors++;
      $display("FAIL err_refetch_data got %h want 00000140", d);
    end
    fetch(32'h500, d, lat, ars);
    checks++;
    if (ars !== 0 || lat !== 1) begin
      errors++;
      $display("FAIL err_hit got ar=%0d lat=%0d want 0/1",
               ars, lat);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
